// File: rtl/render_seq_pkg.sv
// Shared constants for the render command sequencer: FSM encoding, render
// register map, command word layout and STATUS register layout.
package render_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_W_CODE    = 3'd1;
  localparam logic [2:0] ST_W_X       = 3'd2;
  localparam logic [2:0] ST_W_Y       = 3'd3;
  localparam logic [2:0] ST_W_START   = 3'd4;
  localparam logic [2:0] ST_SETTLE    = 3'd5;
  localparam logic [2:0] ST_WAIT_DONE = 3'd6;

  localparam logic [3:0] RA_X     = 4'd1;
  localparam logic [3:0] RA_Y     = 4'd2;
  localparam logic [3:0] RA_CODE  = 4'd4;
  localparam logic [3:0] RA_START = 4'd6;

  localparam int CMD_W        = 26;
  localparam int CMD_X_LSB    = 0;
  localparam int CMD_Y_LSB    = 9;
  localparam int CMD_CODE_LSB = 17;
  localparam int CMD_NOXY_BIT = 25;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic       no_xy;
    logic [7:0] code;
    logic [7:0] y;
    logic [8:0] x;
  } cmd_t;

  localparam int STS_COUNT_LSB = 0;
  localparam int STS_EMPTY_BIT = 8;
  localparam int STS_FULL_BIT  = 9;
  localparam int STS_OVF_BIT   = 10;
  localparam int STS_BUSY_BIT  = 11;
  localparam int STS_DONE_LSB  = 16;

  localparam int CTRL_CLR_OVF_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous command FIFO with flush; the head entry is read straight out of
// the storage array so a pop can load it in the same cycle.
module render_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       push_ok_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign pop_ok    = pop_i && !empty_o;
  // A pop frees the slot the push would overwrite, so full is no obstacle then.
  assign push_ok   = push_i && (!full_o || pop_ok);
  assign push_ok_o = push_ok;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // NOTE: storage has no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/render_cmd_sequencer.sv
// Drains queued draw commands into the render slave as CODE, X, Y, START
// register writes, then waits for the plot to finish before the next command.
module render_cmd_sequencer
  import render_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_address,
  input  logic        host_write,
  input  logic [31:0] host_writedata,
  input  logic        host_read,
  output logic [31:0] host_readdata,
  output logic [3:0]  master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  cmd_t             cmd_q;
  logic [15:0]      done_q;
  logic             ovf_q;

  logic             push, ctrl_wr, flush, pop, push_ok, wr_accept;
  logic [CMD_W-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic [31:0]      status;
  logic             unused_wdata;

  assign push      = host_write && !host_address;
  assign ctrl_wr   = host_write && host_address;
  assign flush     = ctrl_wr && host_writedata[CTRL_FLUSH_BIT];
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;
  assign wr_accept = master_write && !master_waitrequest;
  assign unused_wdata = ^host_writedata[31:CMD_W];

  render_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .flush_i   (flush),
    .wdata_i   (host_writedata[CMD_W-1:0]),
    .head_o    (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .push_ok_o (push_ok)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE:    if (!fifo_empty) state_d = ST_W_CODE;
      ST_W_CODE:  if (wr_accept) state_d = cmd_q.no_xy ? ST_W_START : ST_W_X;
      ST_W_X:     if (wr_accept) state_d = ST_W_Y;
      ST_W_Y:     if (wr_accept) state_d = ST_W_START;
      ST_W_START: if (wr_accept) begin
        state_d  = (SETTLE == 0) ? ST_WAIT_DONE : ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE - 1)) state_d = ST_WAIT_DONE;
        else settle_d = settle_q + 1'b1;
      end
      // Render holds waitrequest while plotting, so its level doubles as busy.
      ST_WAIT_DONE: if (!master_waitrequest) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      cmd_q    <= '0;
      done_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      if (pop) cmd_q <= fifo_head;
      if (state_q == ST_W_START && wr_accept) done_q <= done_q + 1'b1;
      if (ctrl_wr && host_writedata[CTRL_CLR_OVF_BIT]) ovf_q <= 1'b0;
      else if (push && !push_ok)                      ovf_q <= 1'b1;
    end
  end

  // Outputs decode from registered state only, so reset drops the write at once.
  always_comb begin
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    case (state_q)
      ST_W_CODE: begin
        master_write     = 1'b1;
        master_address   = RA_CODE;
        master_writedata = 32'(cmd_q.code);
      end
      ST_W_X: begin
        master_write     = 1'b1;
        master_address   = RA_X;
        master_writedata = 32'(cmd_q.x);
      end
      ST_W_Y: begin
        master_write     = 1'b1;
        master_address   = RA_Y;
        master_writedata = 32'(cmd_q.y);
      end
      ST_W_START: begin
        master_write   = 1'b1;
        master_address = RA_START;
      end
      default: ;
    endcase
  end

  always_comb begin
    status                              = '0;
    status[STS_COUNT_LSB +: 8]          = 8'(fifo_count);
    status[STS_EMPTY_BIT]               = fifo_empty;
    status[STS_FULL_BIT]                = fifo_full;
    status[STS_OVF_BIT]                 = ovf_q;
    status[STS_BUSY_BIT]                = (state_q != ST_IDLE);
    status[STS_DONE_LSB +: 16]          = done_q;
    host_readdata = '0;
    if (host_read && !host_address) host_readdata = status;
  end

endmodule

// File: tb/tb_render_cmd_sequencer.sv
// Randomised and directed bench for render_cmd_sequencer: a reference model
// predicts render writes and STATUS; a monitor scores every accepted write.
module tb_render_cmd_sequencer;

  localparam int DEPTH  = 16;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_address = 1'b0;
  logic        host_write = 1'b0;
  logic [31:0] host_writedata = '0;
  logic        host_read = 1'b0;
  logic [31:0] host_readdata;
  logic [3:0]  master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_waitrequest = 1'b0;

  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;

  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_done = 0;
  int   wait_mode = 0;    // 0 ready, 1 stall all, 2 random, 3 stall stall_addr, 4 busy unless writing
  logic [3:0] stall_addr = '0;
  int   stall_left = 0;

  render_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .host_address       (host_address),
    .host_write         (host_write),
    .host_writedata     (host_writedata),
    .host_read          (host_read),
    .host_readdata      (host_readdata),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_waitrequest (master_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: expand a command word into the register writes render should see.
  task automatic model_cmd(input logic [31:0] w);
    exp_q.push_back('{4'd4, {24'd0, w[24:17]}});
    if (!w[25]) begin
      exp_q.push_back('{4'd1, {23'd0, w[8:0]}});
      exp_q.push_back('{4'd2, {24'd0, w[16:9]}});
    end
    exp_q.push_back('{4'd6, 32'd0});
  endtask

  function automatic logic [31:0] sts(input int cnt, input bit ovf, input bit busy, input int done);
    logic [31:0] s;
    s        = '0;
    s[7:0]   = cnt[7:0];
    s[8]     = (cnt == 0);
    s[9]     = (cnt == DEPTH);
    s[10]    = ovf;
    s[11]    = busy;
    s[31:16] = done[15:0];
    return s;
  endfunction

  // Render-side waitrequest driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (wait_mode)
      1: master_waitrequest = 1'b1;
      2: master_waitrequest = ($urandom_range(0, 9) < 3);
      3: begin
        if (master_write && master_address == stall_addr && stall_left > 0) begin
          master_waitrequest = 1'b1;
          stall_left--;
        end else master_waitrequest = 1'b0;
      end
      4: master_waitrequest = !master_write;
      default: master_waitrequest = 1'b0;
    endcase
  end

  // Monitor: scores accepted writes and checks address/data hold during stalls.
  logic        stall_pend = 1'b0;
  logic [3:0]  held_a;
  logic [31:0] held_d;
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n || !master_write) stall_pend = 1'b0;
    else begin
      if (stall_pend) begin
        check("stall_addr_stable", {28'd0, master_address}, {28'd0, held_a});
        check("stall_data_stable", master_writedata, held_d);
      end
      if (master_waitrequest) begin
        stall_pend = 1'b1;
        held_a = master_address;
        held_d = master_writedata;
      end else begin
        stall_pend = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_write: got addr %0d data 0x%08h, expected no write", master_address, master_writedata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {28'd0, master_address}, {28'd0, e.a});
          check("wr_data", master_writedata, e.d);
        end
      end
    end
  end

  // Host bus tasks: entered and left at 1 time unit after a rising edge.
  task automatic host_wr(input logic a, input logic [31:0] d);
    host_address   = a;
    host_writedata = d;
    host_write     = 1'b1;
    @(posedge clk); #1;
    host_write     = 1'b0;
  endtask

  task automatic host_rd(input logic a, output logic [31:0] d);
    host_address = a;
    host_read    = 1'b1;
    #1;
    d = host_readdata;
    @(posedge clk); #1;
    host_read = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input bit model);
    if (model) model_cmd(w);
    host_wr(1'b0, w);
  endtask

  task automatic check_status(input string name, input logic [31:0] exp_v);
    logic [31:0] d;
    host_rd(1'b0, d);
    check(name, d, exp_v);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] d;
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      host_rd(1'b0, d);
      if (!d[11] && d[8]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_idle_timeout: got STATUS 0x%08h, expected idle and empty", d);
    end
  endtask

  task automatic wait_master(input logic [3:0] a, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (master_write && master_address == a) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_master_timeout: got addr %0d, expected write to %0d", master_address, a);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    // Reset state
    #12;
    check("rst_master_write", {31'd0, master_write}, 32'd0);
    check("rst_master_addr", {28'd0, master_address}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_status("rst_status", 32'h0000_0100);
    check_status("ctrl_read", 32'h0000_0100);
    begin
      logic [31:0] d;
      host_rd(1'b1, d);
      check("ctrl_read_zero", d, 32'd0);
    end

    // Background command: no_xy, two writes, busy held by render afterwards
    wait_mode = 4;
    push(32'h0200_0000 | (32'hFC << 17), 1);
    exp_done++;
    repeat (8) begin @(posedge clk); #1; end
    check_status("bg_busy_done", sts(0, 0, 1, exp_done));
    check("bg_all_writes", exp_q.size(), 0);
    wait_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    check_status("bg_idle", sts(0, 0, 0, exp_done));

    // Bird command: X write stalled for three cycles
    stall_addr = 4'd1; stall_left = 3; wait_mode = 3;
    push(32'd20 | (32'd20 << 9) | (32'd1 << 17), 1);
    exp_done++;
    wait_idle(200);
    check_status("bird_status", sts(0, 0, 0, exp_done));

    // Overflow: render stalls everything, 18 pushes
    wait_mode = 1;
    for (int i = 0; i < 18; i++) begin
      w = $urandom;
      push(w, i == 0);
    end
    check_status("ovf_full", sts(16, 1, 1, exp_done));
    host_wr(1'b1, 32'd1);
    check_status("ovf_cleared", sts(16, 0, 1, exp_done));
    host_wr(1'b1, 32'd2);
    check_status("ovf_flushed", sts(0, 0, 1, exp_done));
    wait_mode = 0;
    exp_done++;
    wait_idle(200);
    check_status("ovf_done", sts(0, 0, 0, exp_done));

    // Flush with the sequencer parked in W_X and five commands queued
    stall_addr = 4'd1; stall_left = 1000; wait_mode = 3;
    for (int i = 0; i < 6; i++) push($urandom & ~(32'd1 << 25), 1);
    wait_master(4'd1, 50);
    check_status("flush_pre", sts(5, 0, 1, exp_done));
    host_wr(1'b1, 32'd2);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    check_status("flush_post", sts(0, 0, 1, exp_done));
    exp_done++;
    stall_left = 0;
    wait_idle(200);
    check_status("flush_done", sts(0, 0, 0, exp_done));

    // Randomised bursts with random render stalls
    wait_mode = 2;
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        int g;
        push($urandom, 1);
        exp_done++;
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
      end
      wait_idle(3000);
      wait_mode = 0;
      repeat (2) begin @(posedge clk); #1; end
      check_status("rand_status", sts(0, 0, 0, exp_done));
      wait_mode = 2;
    end
    wait_mode = 0;
    check("rand_all_writes", exp_q.size(), 0);

    // Asynchronous reset while the Y write is stalled
    stall_addr = 4'd2; stall_left = 1000; wait_mode = 3;
    push(32'd7 | (32'd9 << 9) | (32'd3 << 17), 1);
    wait_master(4'd2, 50);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_done = 0;
    #1;
    check("arst_write_drop", {31'd0, master_write}, 32'd0);
    stall_left = 0; wait_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check_status("arst_status", 32'h0000_0100);

    check("leftover_writes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
